// File: rtl/move_ctrl_if.sv
// Button and command-strobe bundle between the board pins, the move controller
// and the block position tracker.
interface move_ctrl_if;
  logic btn_left;
  logic btn_right;
  logic btn_rot;
  logic btn_down;
  logic pause;
  logic lock;
  logic drop;
  logic left;
  logic right;
  logic ro;

  modport master (
    output btn_left, btn_right, btn_rot, btn_down, pause, lock,
    input  drop, left, right, ro
  );

  modport slave (
    input  btn_left, btn_right, btn_rot, btn_down, pause, lock,
    output drop, left, right, ro
  );
endinterface

// File: rtl/move_ctrl.sv
// Debounces player buttons, adds gravity and horizontal auto-repeat, and emits one
// command strobe per cycle. Optional feature macro: MOVE_CTRL_AUTO_REPEAT_EN.
module move_ctrl #(
  parameter int DEB_CYCLES  = 250000,
  parameter int GRAV_CYCLES = 25000000,
  parameter int SOFT_CYCLES = 2500000,
  parameter int REP_DELAY   = 10000000,
  parameter int REP_RATE    = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  move_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int GW = $clog2(GRAV_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_CYCLES - 1);
  localparam logic [GW-1:0] SOFT_LAST = GW'(SOFT_CYCLES - 1);

  // Bit order everywhere: 0 drop/down, 1 left, 2 right, 3 rotate.
  logic [3:0] btn_raw;
  logic [3:0] held;
  logic [3:0] rise;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] pend_reg;
  logic [3:0] pend_next;
  logic [3:0] strobe_reg;
  logic [1:0] rpt_req;

  assign btn_raw = {bus.btn_rot, bus.btn_right, bus.btn_left, bus.btn_down};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic          s1_reg;
      logic          s2_reg;
      logic          deb_reg;
      logic          deb_d_reg;
      logic          block_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          block_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= btn_raw[gi];
          s2_reg    <= s1_reg;
          deb_d_reg <= deb_reg;
          if (s2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          // A button held across a lock stays ignored until it is seen released.
          block_reg <= bus.lock | (block_reg & deb_reg);
        end
      end

      assign held[gi] = deb_reg & ~block_reg;
      assign rise[gi] = deb_reg & ~deb_d_reg & ~block_reg & ~bus.lock;
    end
  endgenerate

  logic [GW-1:0] grav_cnt_reg;
  logic [GW-1:0] grav_cnt_next;
  logic [GW-1:0] grav_last;
  logic          grav_fire;

  // Using >= lets a counter already past the soft period fire right after the switch.
  always_comb begin
    grav_last     = held[0] ? SOFT_LAST : GRAV_LAST;
    grav_fire     = 1'b0;
    grav_cnt_next = grav_cnt_reg;
    if (bus.lock) begin
      grav_cnt_next = '0;
    end else if (!bus.pause) begin
      if (grav_cnt_reg >= grav_last) begin
        grav_fire     = 1'b1;
        grav_cnt_next = '0;
      end else begin
        grav_cnt_next = grav_cnt_reg + 1'b1;
      end
    end
  end

`ifdef MOVE_CTRL_AUTO_REPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  logic both_horiz;
  logic held_unused;
  assign both_horiz  = g_btn[1].deb_reg & g_btn[2].deb_reg;
  assign held_unused = held[3];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rpt
      rpt_state_t    state_reg;
      rpt_state_t    state_next;
      logic [RW-1:0] cnt_reg;
      logic [RW-1:0] cnt_next;
      logic          fire;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= RPT_IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fire       = 1'b0;
        if (bus.lock || !held[gi+1] || both_horiz) begin
          state_next = RPT_IDLE;
          cnt_next   = '0;
        end else if (!bus.pause) begin
          case (state_reg)
            RPT_IDLE: begin
              state_next = RPT_DELAY;
              cnt_next   = '0;
            end
            RPT_DELAY: begin
              if (cnt_reg == DELAY_LAST) begin
                fire       = 1'b1;
                state_next = RPT_REPEAT;
                cnt_next   = '0;
              end else begin
                cnt_next = cnt_reg + 1'b1;
              end
            end
            RPT_REPEAT: begin
              if (cnt_reg == RATE_LAST) begin
                fire     = 1'b1;
                cnt_next = '0;
              end else begin
                cnt_next = cnt_reg + 1'b1;
              end
            end
            default: begin
              state_next = RPT_IDLE;
              cnt_next   = '0;
            end
          endcase
        end
      end

      assign rpt_req[gi] = fire;
    end
  endgenerate
`else
  logic [34:0] rep_unused;
  assign rep_unused = {held[3:1], 32'(REP_DELAY ^ REP_RATE)};
  assign rpt_req    = 2'b00;
`endif

  // Lowest set bit wins, which is the tracker's drop>left>right>ro priority.
  always_comb begin
    req   = {rise[3], rise[2] | rpt_req[1], rise[1] | rpt_req[0], rise[0] | grav_fire};
    grant = 4'b0000;
    if (!bus.pause && !bus.lock) begin
      grant = pend_reg & (~pend_reg + 4'd1);
    end
    pend_next = bus.lock ? 4'b0000 : ((pend_reg & ~grant) | req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grav_cnt_reg <= '0;
      pend_reg     <= 4'b0000;
      strobe_reg   <= 4'b0000;
    end else begin
      grav_cnt_reg <= grav_cnt_next;
      pend_reg     <= pend_next;
      strobe_reg   <= grant;
    end
  end

  assign bus.drop  = strobe_reg[0];
  assign bus.left  = strobe_reg[1];
  assign bus.right = strobe_reg[2];
  assign bus.ro    = strobe_reg[3];

endmodule
